// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feeder: default geometry, feeder FSM states
// and the helper that sizes the vector-count field from the maximum operation length.
package systolic_pkg;

  localparam int WIDTH_DEF    = 16;
  localparam int FRAC_BIT_DEF = 10;
  localparam int ROWS_DEF     = 4;
  localparam int MAX_K_DEF    = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } feeder_state_e;

  function automatic int len_w(input int max_k);
    return $clog2(max_k + 1);
  endfunction

endpackage

// File: rtl/systolic_feeder_skew_chain.sv
// Per-row delay line for the diagonal skew: DEPTH registers shifted together on en,
// synchronously cleared on clr; q is the last stage.
module skew_chain #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d = stage_q;
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) stage_d[i] = '0;
    end else if (en) begin
      stage_d[0] = d;
      for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Skewed operand feeder for a pe systolic array: row r is delayed r cycles, then zeros flush
// the skew and done pulses. Optional FEEDER_STALL_CNT_EN adds a saturating stall counter.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int ROWS  = ROWS_DEF,
  parameter  int MAX_K = MAX_K_DEF,
  localparam int LEN_W = len_w(MAX_K)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROWS*WIDTH-1:0] in_vec,
  output logic [ROWS*WIDTH-1:0] a_row,
  output logic [ROWS*WIDTH-1:0] y_seed,
  output logic                  array_en,
  output logic                  busy,
  output logic                  done
`ifdef FEEDER_STALL_CNT_EN
  ,output logic [15:0]          stall_cnt
`endif
);

  localparam int F_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [F_W-1:0] F_LAST = F_W'((ROWS > 1) ? ROWS - 2 : 0);

  feeder_state_e    state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] k_cnt_q, k_cnt_d;
  logic [F_W-1:0]   f_cnt_q, f_cnt_d;
  logic             array_en_q, done_q;
  logic             shift, shift_zero, clr;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    k_cnt_d    = k_cnt_q;
    f_cnt_d    = f_cnt_q;
    shift      = 1'b0;
    shift_zero = 1'b0;
    clr        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            len_d   = len;
            k_cnt_d = '0;
            state_d = ST_FEED;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_FEED: begin
        if (in_valid) begin
          shift   = 1'b1;
          k_cnt_d = k_cnt_q + LEN_W'(1);
          if (k_cnt_q == len_q - LEN_W'(1)) begin
            f_cnt_d = '0;
            if (ROWS > 1) state_d = ST_FLUSH;
            else          state_d = ST_DONE;
          end
        end
      end
      ST_FLUSH: begin
        shift      = 1'b1;
        shift_zero = 1'b1;
        f_cnt_d    = f_cnt_q + F_W'(1);
        if (f_cnt_q == F_LAST) state_d = ST_DONE;
      end
      default: begin
        clr     = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // array_en and done are registered so they line up with the registered a_row stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      k_cnt_q    <= '0;
      f_cnt_q    <= '0;
      array_en_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      k_cnt_q    <= k_cnt_d;
      f_cnt_q    <= f_cnt_d;
      array_en_q <= shift;
      done_q     <= (state_q == ST_DONE);
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [WIDTH-1:0] chain_d;
    assign chain_d = shift_zero ? '0 : in_vec[r*WIDTH +: WIDTH];

    skew_chain #(
      .DEPTH(r + 1),
      .WIDTH(WIDTH)
    ) u_chain (
      .clk(clk),
      .rst(rst),
      .en (shift),
      .clr(clr),
      .d  (chain_d),
      .q  (a_row[r*WIDTH +: WIDTH])
    );
  end

  assign in_ready = (state_q == ST_FEED);
  assign busy     = (state_q != ST_IDLE);
  assign array_en = array_en_q;
  assign done     = done_q;
  assign y_seed   = '0;

`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == ST_IDLE && start) begin
      stall_d = '0;
    end else if (state_q == ST_FEED && !in_valid && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule
